// File: rtl/matrix_uart_printer.sv
// matrix_uart_printer
// Walks a stored matrix in row-major order through the storage read port and
// streams every element to the UART transmitter as unsigned decimal ASCII.
// Columns are separated by a space and each row ends with CR LF.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle print request, taken only when idle
//   mat_id, dim_m, dim_n  matrix id and row/column count, sampled with start
//   rd_req, rd_id,        read request (held until rd_valid) and element
//   rd_row, rd_col          address
//   rd_valid, rd_data     read response strobe and element value
//   tx_data, tx_start     byte to transmit and its one-cycle strobe
//   tx_busy               transmitter busy
//   busy                  print in progress
//   done, err             one-cycle completion / abort pulses
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// CHECK   | validate the latched dimensions
// REQ     | read outstanding, timeout timer running
// CONV    | turn the captured element into its byte queue
// EMIT    | strobe the queue head once the transmitter is free
// WAIT_TX | wait for the transmitter to take the byte, then pop
// DONE    | done pulse
// ERR     | err pulse

module matrix_uart_printer #(
  parameter int MAX_DIM    = 5,
  parameter int ID_W       = 4,
  parameter int DIM_W      = 3,
  parameter int RD_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ID_W-1:0]  mat_id,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_n,
  output logic             rd_req,
  output logic [ID_W-1:0]  rd_id,
  output logic [DIM_W-1:0] rd_row,
  output logic [DIM_W-1:0] rd_col,
  input  logic             rd_valid,
  input  logic [7:0]       rd_data,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               TMR_W    = $clog2(RD_TIMEOUT + 1);
  // Down-counter loaded on entry to REQ; reaching zero still unanswered
  // means rd_req has been high for RD_TIMEOUT cycles.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RD_TIMEOUT - 1);
  localparam logic [DIM_W-1:0] DIM_MAX  = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE      = DIM_W'(1);
  localparam logic [7:0]       ASCII_0  = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_CONV, S_EMIT, S_WAIT_TX, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [DIM_W-1:0] dim_m_q;
  logic [DIM_W-1:0] dim_n_q;
  logic [TMR_W-1:0] tmr;
  logic [7:0]       val_q;
  logic [7:0]       q [0:4];
  logic [2:0]       q_len;
  logic [2:0]       q_head;
  logic             wait_first;

  logic             last_col;
  logic             last_row;
  logic             dims_bad;
  logic [7:0]       hund;
  logic [7:0]       tens;
  logic [7:0]       ones;
  logic [2:0]       n_dig;
  logic [2:0]       len_next;
  logic [7:0]       q_next [0:4];

  assign last_col = (rd_col == dim_n_q - ONE);
  assign last_row = (rd_row == dim_m_q - ONE);
  assign dims_bad = (dim_m_q == '0) || (dim_n_q == '0) ||
                    (dim_m_q > DIM_MAX) || (dim_n_q > DIM_MAX);

  // Decimal text for the captured element plus its separator.
  always_comb begin
    hund     = val_q / 8'd100;
    tens     = (val_q / 8'd10) % 8'd10;
    ones     = val_q % 8'd10;
    n_dig    = 3'd1;
    len_next = 3'd2;
    for (int i = 0; i < 5; i++) q_next[i] = 8'h00;
    if (hund != 8'd0) begin
      q_next[0] = ASCII_0 + hund;
      q_next[1] = ASCII_0 + tens;
      q_next[2] = ASCII_0 + ones;
      n_dig     = 3'd3;
    end else if (tens != 8'd0) begin
      q_next[0] = ASCII_0 + tens;
      q_next[1] = ASCII_0 + ones;
      n_dig     = 3'd2;
    end else begin
      q_next[0] = ASCII_0 + ones;
      n_dig     = 3'd1;
    end
    if (last_col) begin
      q_next[n_dig]        = 8'h0D;
      q_next[n_dig + 3'd1] = 8'h0A;
      len_next             = n_dig + 3'd2;
    end else begin
      q_next[n_dig] = 8'h20;
      len_next      = n_dig + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_req     <= 1'b0;
      rd_id      <= '0;
      rd_row     <= '0;
      rd_col     <= '0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dim_m_q    <= '0;
      dim_n_q    <= '0;
      tmr        <= '0;
      val_q      <= 8'h00;
      q_len      <= 3'd0;
      q_head     <= 3'd0;
      wait_first <= 1'b0;
      for (int i = 0; i < 5; i++) q[i] <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_id   <= mat_id;
            dim_m_q <= dim_m;
            dim_n_q <= dim_n;
            busy    <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (dims_bad) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end else begin
            rd_row <= '0;
            rd_col <= '0;
            rd_req <= 1'b1;
            tmr    <= TMR_LOAD;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          // A response on the terminal cycle still wins over the timeout.
          if (rd_valid) begin
            val_q  <= rd_data;
            rd_req <= 1'b0;
            state  <= S_CONV;
          end else if (tmr == '0) begin
            rd_req <= 1'b0;
            err    <= 1'b1;
            busy   <= 1'b0;
            state  <= S_ERR;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CONV: begin
          q      <= q_next;
          q_len  <= len_next;
          q_head <= 3'd0;
          state  <= S_EMIT;
        end
        S_EMIT: begin
          if (!tx_busy) begin
            tx_data    <= q[q_head];
            tx_start   <= 1'b1;
            wait_first <= 1'b1;
            state      <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          // The transmitter raises tx_busy a cycle after the strobe, so the
          // first cycle here cannot be trusted.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            if (q_head + 3'd1 != q_len) begin
              q_head <= q_head + 3'd1;
              state  <= S_EMIT;
            end else if (last_col && last_row) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              if (last_col) begin
                rd_row <= rd_row + ONE;
                rd_col <= '0;
              end else begin
                rd_col <= rd_col + ONE;
              end
              rd_req <= 1'b1;
              tmr    <= TMR_LOAD;
              state  <= S_REQ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_uart_printer.sv
// tb_matrix_uart_printer
// Drives matrix_uart_printer with a behavioural storage responder and a UART
// TX model, and compares the emitted text against a string built directly
// from the stored matrix with $sformatf.

module tb_matrix_uart_printer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] mat_id;
  logic [2:0] dim_m;
  logic [2:0] dim_n;
  logic       rd_req;
  logic [3:0] rd_id;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       done;
  logic       err;

  matrix_uart_printer dut (
    .clk(clk), .rst(rst), .start(start), .mat_id(mat_id),
    .dim_m(dim_m), .dim_n(dim_n), .rd_req(rd_req), .rd_id(rd_id),
    .rd_row(rd_row), .rd_col(rd_col), .rd_valid(rd_valid), .rd_data(rd_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Storage contents and per-run environment settings.
  logic [7:0] mem [16][8][8];
  int edge_vals [9] = '{0, 1, 9, 10, 99, 100, 199, 200, 255};
  int cur_id, rd_lat, tx_len, force_after;
  bit mem_dead;

  // Observations collected per run.
  logic [7:0] recv[$];
  int done_cnt, err_cnt, req_hi;
  int tx_viol, spacing_viol, stat_viol, addr_viol, id_viol;
  int first_tx_cyc, first_valid_cyc, last_tx_cyc;
  int tx_left, force_left;
  bit prev_req;
  logic [2:0] prev_row, prev_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string expect_text(input int id, input int m, input int n);
    string s;
    s = "";
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        s = {s, $sformatf("%0d", mem[id][r][c])};
        if (c == n - 1) s = {s, "\r\n"};
        else            s = {s, " "};
      end
    return s;
  endfunction

  // Storage: answers each request after rd_lat cycles of rd_req.
  initial begin : storage
    int age;
    age = 0;
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (rd_req) begin
        if (!mem_dead && age == rd_lat - 1) begin
          rd_valid = 1'b1;
          rd_data  = mem[rd_id][rd_row][rd_col];
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        age++;
      end else begin
        age = 0;
      end
    end
  end

  // TX model and protocol monitor.
  initial begin : monitor
    tx_busy = 1'b0;
    tx_left = 0;
    force_left = 0;
    forever begin
      @(negedge clk);
      if (force_left > 0) force_left--;
      if (tx_start) begin
        if (tx_busy) tx_viol++;
        if (last_tx_cyc >= 0 && cyc - last_tx_cyc < 2) spacing_viol++;
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        last_tx_cyc = cyc;
        recv.push_back(tx_data);
        tx_left = tx_len;
        if (recv.size() == force_after) force_left = 100;
      end else if (tx_left > 0) begin
        tx_left--;
      end
      tx_busy = (tx_left > 0) || (force_left > 0);
      if (done) begin done_cnt++; if (busy) stat_viol++; end
      if (err)  begin err_cnt++;  if (busy) stat_viol++; end
      if (rd_req) begin
        req_hi++;
        if (32'(rd_id) != cur_id) id_viol++;
        if (prev_req && (rd_row != prev_row || rd_col != prev_col)) addr_viol++;
      end
      prev_req = rd_req;
      prev_row = rd_row;
      prev_col = rd_col;
    end
  end

  task automatic setup_run(input int id, input int lat, input int txl, input bit dead, input int frc);
    cur_id = id; rd_lat = lat; tx_len = txl; mem_dead = dead; force_after = frc;
    recv.delete();
    done_cnt = 0; err_cnt = 0; req_hi = 0;
    tx_viol = 0; spacing_viol = 0; stat_viol = 0; addr_viol = 0; id_viol = 0;
    first_tx_cyc = -1; first_valid_cyc = -1; last_tx_cyc = -1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    chk({pfx, "_rd_req"},   32'(rd_req),   0);
    chk({pfx, "_tx_start"}, 32'(tx_start), 0);
    chk({pfx, "_busy"},     32'(busy),     0);
    chk({pfx, "_done"},     32'(done),     0);
    chk({pfx, "_err"},      32'(err),      0);
    chk({pfx, "_rd_row"},   32'(rd_row),   0);
    chk({pfx, "_rd_col"},   32'(rd_col),   0);
    chk({pfx, "_rd_id"},    32'(rd_id),    0);
    chk({pfx, "_tx_data"},  32'(tx_data),  0);
  endtask

  task automatic run_print(input string name, input int id, input int m, input int n,
                           input int lat, input int txl, input bit dead,
                           input int frc, input bit extra);
    bit bad, fin;
    string exp_s;
    bad = (m == 0) || (n == 0) || (m > 5) || (n > 5);
    for (int i = 0; i < 500 && tx_busy; i++) @(negedge clk);
    @(negedge clk);
    setup_run(id, lat, txl, dead, frc);
    start = 1'b1; mat_id = 4'(id); dim_m = 3'(m); dim_n = 3'(n);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_t1"}, 32'(busy), 1);
    @(negedge clk);
    chk({name, "_rd_req_t2"}, 32'(rd_req), bad ? 0 : 1);
    chk({name, "_err_t2"}, 32'(err), bad ? 1 : 0);
    fin = 1'b0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      @(negedge clk);
      #1;
      if (extra && i == 20) begin
        start = 1'b1; mat_id = 4'd5; dim_m = 3'd1; dim_n = 3'd1;
      end else begin
        start = 1'b0;
      end
      fin = (done_cnt + err_cnt) > 0;
    end
    start = 1'b0;
    chk({name, "_finished"}, 32'(fin), 1);
    repeat (6) @(negedge clk);
    #1;
    if (bad || dead) begin
      chk({name, "_done_cnt"}, done_cnt, 0);
      chk({name, "_err_cnt"}, err_cnt, 1);
      chk({name, "_tx_cnt"}, 32'(recv.size()), 0);
      chk({name, "_req_cycles"}, req_hi, bad ? 0 : 255);
    end else begin
      exp_s = expect_text(id, m, n);
      chk({name, "_done_cnt"}, done_cnt, 1);
      chk({name, "_err_cnt"}, err_cnt, 0);
      chk({name, "_len"}, 32'(recv.size()), 32'(exp_s.len()));
      for (int i = 0; i < exp_s.len() && i < recv.size(); i++)
        chk($sformatf("%s_b%0d", name, i), 32'(recv[i]), 32'(exp_s[i]));
      chk({name, "_req_cycles"}, req_hi, lat * m * n);
      chk({name, "_first_tx_lat"}, first_tx_cyc - first_valid_cyc, 3);
    end
    chk({name, "_tx_while_busy"}, tx_viol, 0);
    chk({name, "_tx_spacing"}, spacing_viol, 0);
    chk({name, "_pulse_busy"}, stat_viol, 0);
    chk({name, "_addr_stable"}, addr_viol, 0);
    chk({name, "_rd_id"}, id_viol, 0);
  endtask

  initial begin : main
    bit hit;
    int id, m, n;
    rst = 1'b1; start = 1'b0; mat_id = 4'd0; dim_m = 3'd0; dim_n = 3'd0;
    setup_run(0, 1, 0, 1'b0, -1);
    for (int a = 0; a < 16; a++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) mem[a][r][c] = 8'h00;
    mem[1][0][0] = 8'd1; mem[1][0][1] = 8'd2;
    mem[1][1][0] = 8'd3; mem[1][1][1] = 8'd4;
    mem[2][0][0] = 8'd0; mem[2][0][1] = 8'd10; mem[2][0][2] = 8'd255;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    run_print("m2x2",       1, 2, 2, 1, 10, 1'b0, -1, 1'b0);
    run_print("row_0_10_255", 2, 1, 3, 1, 2, 1'b0, -1, 1'b0);
    run_print("dim_m0",     3, 0, 2, 1, 2, 1'b0, -1, 1'b0);
    run_print("dim_n6",     3, 2, 6, 1, 2, 1'b0, -1, 1'b0);
    run_print("rd_timeout", 3, 2, 2, 1, 2, 1'b1, -1, 1'b0);
    run_print("busy_hold",  1, 2, 2, 1, 10, 1'b0, 1, 1'b1);

    // Reset while the second row's first byte is in flight.
    for (int i = 0; i < 500 && tx_busy; i++) @(negedge clk);
    setup_run(1, 1, 3, 1'b0, -1);
    @(negedge clk);
    start = 1'b1; mat_id = 4'd1; dim_m = 3'd2; dim_n = 3'd2;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (tx_start && rd_row == 3'd1) hit = 1'b1;
    end
    chk("mid_rst_reach_row1", 32'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_rst");
    rst = 1'b0;
    run_print("after_rst", 1, 2, 2, 2, 4, 1'b0, -1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      id = $urandom_range(4, 15);
      m  = $urandom_range(1, 5);
      n  = $urandom_range(1, 5);
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++)
          if ($urandom_range(0, 1) == 1) mem[id][r][c] = 8'(edge_vals[$urandom_range(0, 8)]);
          else                           mem[id][r][c] = 8'($urandom_range(0, 255));
      run_print($sformatf("rand%0d", k), id, m, n,
                $urandom_range(1, 4), $urandom_range(0, 6), 1'b0, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
